// File: rtl/galois_mult_small_pipe.sv
// galois_mult_small_pipe: pipelined (k*x) mod p for a small constant k, with valid/ready backpressure.
module galois_mult_small_pipe #(
    parameter int                N_BITS        = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int                K_BITS        = 5,
    parameter int                CHUNK_BITS    = 27,
    parameter int                SUB_PER_STAGE = 2,
    parameter int                TAG_BITS      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [K_BITS-1:0]   in_k,
    input  logic [N_BITS-1:0]   in_x,
    input  logic [TAG_BITS-1:0] in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_BITS-1:0]   out_result,
    output logic [TAG_BITS-1:0] out_tag,
    output logic                busy
);
    localparam int R   = (K_BITS + SUB_PER_STAGE - 1) / SUB_PER_STAGE;
    localparam int P   = N_BITS + K_BITS;
    localparam int NCH = (N_BITS + CHUNK_BITS - 1) / CHUNK_BITS;
    localparam int PPW = CHUNK_BITS + K_BITS;
    localparam int XW  = NCH * CHUNK_BITS;
    localparam logic [P-1:0] P_EXT = P'(PRIME_MODULUS);

    logic                en;
    logic [XW-1:0]       x_pad;
    logic [P-1:0]        sum;
    logic [R+1:0]        v_q, v_d;
    logic [TAG_BITS-1:0] tag_q [R+2];
    logic [TAG_BITS-1:0] tag_d [R+2];
    logic [PPW-1:0]      pp_q [NCH];
    logic [PPW-1:0]      pp_d [NCH];
    logic [P-1:0]        stg_q [R];
    logic [P-1:0]        stg_d [R];
    logic [N_BITS-1:0]   res_q, res_d;

    // Reduction stage s covers ladder rungs K_BITS-1-s*SUB_PER_STAGE downward.
    function automatic logic [P-1:0] ladder(input logic [P-1:0] r, input int s);
        logic [P-1:0] t;
        t = r;
        for (int i = 0; i < SUB_PER_STAGE; i++) begin
            int j;
            j = K_BITS - 1 - s * SUB_PER_STAGE - i;
            if (j >= 0 && t >= (P_EXT << j))
                t = t - (P_EXT << j);
        end
        return t;
    endfunction

    always_comb begin
        en = !v_q[R+1] || out_ready;
        x_pad = XW'(in_x);
        v_d = en ? {v_q[R:0], in_valid} : v_q;
        tag_d[0] = en ? in_tag : tag_q[0];
        for (int s = 1; s < R + 2; s++)
            tag_d[s] = en ? tag_q[s-1] : tag_q[s];
        for (int c = 0; c < NCH; c++)
            pp_d[c] = en ? PPW'(in_k) * PPW'(x_pad[c*CHUNK_BITS +: CHUNK_BITS]) : pp_q[c];
        sum = '0;
        for (int c = 0; c < NCH; c++)
            sum = sum + (P'(pp_q[c]) << (c * CHUNK_BITS));
        stg_d[0] = en ? sum : stg_q[0];
        for (int s = 1; s < R; s++)
            stg_d[s] = en ? ladder(stg_q[s-1], s - 1) : stg_q[s];
        res_d = en ? N_BITS'(ladder(stg_q[R-1], R - 1)) : res_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            tag_q <= '{default: '0};
            pp_q  <= '{default: '0};
            stg_q <= '{default: '0};
            res_q <= '0;
        end else begin
            v_q   <= v_d;
            tag_q <= tag_d;
            pp_q  <= pp_d;
            stg_q <= stg_d;
            res_q <= res_d;
        end
    end

    assign in_ready   = en;
    assign out_valid  = v_q[R+1];
    assign out_result = res_q;
    assign out_tag    = tag_q[R+1];
    assign busy       = |v_q;
endmodule

// File: tb/tb_galois_mult_small_pipe.sv
// tb_galois_mult_small_pipe: directed and streamed checks of the small-constant modular multiplier.
module tb_galois_mult_small_pipe;
    localparam logic [253:0] PM   = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam logic [60:0]  PM61 = 61'h1FFFFFFFFFFFFFFF;

    typedef struct {
        logic [253:0] r;
        logic [7:0]   t;
    } exp_t;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [4:0]   in_k;
    logic [253:0] in_x, out_result;
    logic [7:0]   in_tag, out_tag;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [2:0]   b_k;
    logic [60:0]  b_x, b_res;
    logic [7:0]   b_tag, b_out_tag;

    int           n_chk = 0;
    int           n_pass = 0;
    int           n_del = 0;
    exp_t         sb[$];
    logic         hold_prev = 0;
    logic [253:0] hold_r;
    logic [7:0]   hold_t;

    always #5 clk = ~clk;

    galois_mult_small_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_k(in_k), .in_x(in_x), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    galois_mult_small_pipe #(
        .N_BITS(61), .PRIME_MODULUS(PM61), .K_BITS(3),
        .CHUNK_BITS(16), .SUB_PER_STAGE(1), .TAG_BITS(8)
    ) dut61 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_k(b_k), .in_x(b_x), .in_tag(b_tag), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_result(b_res), .out_tag(b_out_tag), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [253:0] model(input logic [4:0] k, input logic [253:0] x);
        logic [511:0] t;
        t = 512'(k) * 512'(x);
        t = t % 512'(PM);
        return t[253:0];
    endfunction

    task automatic new_op();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        w = w % 256'(PM);
        in_x   = w[253:0];
        in_k   = 5'($urandom);
        in_tag = 8'($urandom);
    endtask

    // One clock of bookkeeping: hold stability, scoreboard pop on delivery, push on acceptance.
    task automatic cycle(output logic acc);
        exp_t e;
        @(negedge clk);
        if (hold_prev) begin
            chk("hold_valid", 256'(out_valid), 256'd1);
            chk("hold_result", 256'(out_result), 256'(hold_r));
            chk("hold_tag", 256'(out_tag), 256'(hold_t));
        end
        hold_prev = out_valid && !out_ready;
        hold_r = out_result;
        hold_t = out_tag;
        if (out_valid && out_ready) begin
            n_del++;
            if (sb.size() == 0) chk("extra_result", 256'd1, 256'd0);
            else begin
                e = sb.pop_front();
                chk("result", 256'(out_result), 256'(e.r));
                chk("tag", 256'(out_tag), 256'(e.t));
            end
        end
        acc = in_valid && in_ready;
        if (acc) sb.push_back('{model(in_k, in_x), in_tag});
        @(posedge clk);
        #1;
    endtask

    task automatic single(input logic [4:0] k, input logic [253:0] x, input logic [7:0] tg,
                          input logic [253:0] exp, input string name);
        int lat, bc;
        in_k = k; in_x = x; in_tag = tg; in_valid = 1; out_ready = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        lat = 1;
        bc = 0;
        while (!out_valid && lat < 20) begin
            bc += int'(busy);
            @(posedge clk);
            #1;
            lat++;
        end
        bc += int'(busy);
        chk({name, "_latency"}, 256'(lat), 256'd5);
        chk({name, "_result"}, 256'(out_result), 256'(exp));
        chk({name, "_tag"}, 256'(out_tag), 256'(tg));
        @(posedge clk);
        #1;
        chk({name, "_busy_cycles"}, 256'(bc), 256'd5);
        chk({name, "_idle"}, 256'({busy, out_valid}), 256'd0);
    endtask

    initial begin
        logic acc;
        int   sent, g, d0, nacc, lat, stale;
        in_valid = 0; out_ready = 1; in_k = 0; in_x = 0; in_tag = 0;
        b_in_valid = 0; b_out_ready = 1; b_k = 0; b_x = 0; b_tag = 0;
        #2;
        chk("rst_out_valid", 256'(out_valid), 256'd0);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_result", 256'(out_result), 256'd0);
        chk("rst_tag", 256'(out_tag), 256'd0);
        chk("rst_in_ready", 256'(in_ready), 256'd1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        single(5'd3, 254'd5, 8'hA1, 254'd15, "k3x5");
        single(5'd31, PM - 254'd1, 8'hB2, PM - 254'd31, "k31_pm1");
        single(5'd0, PM - 254'd1, 8'hC3, 254'd0, "k0_pm1");
        single(5'd1, PM - 254'd1, 8'hD4, PM - 254'd1, "k1_pm1");
        single(5'd2, (PM + 254'd1) >> 1, 8'hE5, 254'd1, "k2_half");

        // Random stream with 50% output backpressure.
        d0 = n_del; sent = 0; g = 0;
        new_op();
        in_valid = 1;
        while (sent < 200 && g < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            cycle(acc);
            if (acc) begin
                sent++;
                if (sent < 200) new_op();
                else in_valid = 0;
            end
            g++;
        end
        in_valid = 0; out_ready = 1; g = 0;
        while (sb.size() > 0 && g < 50) begin cycle(acc); g++; end
        chk("stream_sent", 256'(sent), 256'd200);
        chk("stream_delivered", 256'(n_del - d0), 256'd200);
        chk("stream_sb_empty", 256'(sb.size()), 256'd0);

        // Fill the pipe with the output stalled, hold, then drain.
        out_ready = 0; nacc = 0; g = 0;
        new_op();
        in_valid = 1;
        while (in_ready && g < 20) begin
            cycle(acc);
            if (acc) begin nacc++; new_op(); end
            g++;
        end
        chk("fill_count", 256'(nacc), 256'd5);
        for (int i = 0; i < 10; i++) begin
            chk("stall_in_ready", 256'(in_ready), 256'd0);
            cycle(acc);
        end
        chk("stall_no_accept", 256'(sb.size()), 256'd5);
        in_valid = 0; out_ready = 1; d0 = n_del;
        for (int i = 0; i < 5; i++) begin
            cycle(acc);
            chk("drain_step", 256'(n_del - d0), 256'(i + 1));
        end
        chk("drain_sb_empty", 256'(sb.size()), 256'd0);

        // Reset with a full, stalled pipe.
        out_ready = 0; g = 0;
        new_op();
        in_valid = 1;
        while (in_ready && g < 20) begin
            cycle(acc);
            if (acc) new_op();
            g++;
        end
        chk("prereset_valid", 256'(out_valid), 256'd1);
        #3;
        rst_n = 0;
        #1;
        chk("midrst_out_valid", 256'(out_valid), 256'd0);
        chk("midrst_result", 256'(out_result), 256'd0);
        chk("midrst_tag", 256'(out_tag), 256'd0);
        chk("midrst_busy", 256'(busy), 256'd0);
        chk("midrst_in_ready", 256'(in_ready), 256'd1);
        sb.delete();
        hold_prev = 0;
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        single(5'd7, 254'd9, 8'h5A, 254'd63, "post_rst");
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            stale += int'(out_valid);
            @(posedge clk);
            #1;
        end
        chk("no_stale", 256'(stale), 256'd0);

        // 61-bit Mersenne parameter set.
        b_k = 3'd7; b_x = PM61 - 61'd1; b_tag = 8'h3C; b_in_valid = 1; b_out_ready = 1;
        @(posedge clk);
        #1;
        b_in_valid = 0;
        lat = 1;
        while (!b_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("p61_latency", 256'(lat), 256'd5);
        chk("p61_result", 256'(b_res), 256'(PM61 - 61'd7));
        chk("p61_tag", 256'(b_out_tag), 256'h3C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
